// File: rtl/bitstream_rom_shifter.sv
// Streams a ROM-resident configuration bitstream MSB-first onto the fabric
// configuration chain, prefetching the next word so shifting never stalls.
module bitstream_rom_shifter #(
  parameter int BITSTREAM_LENGTH = 1024,
  parameter int WORD_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 5,
  parameter int COUNT_WIDTH      = 11
) (
  input  logic                   prog_clk,
  input  logic                   prog_reset_n,
  input  logic                   start,
  output logic                   rom_rd_en,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [WORD_WIDTH-1:0]  rom_data,
  output logic                   config_chain_head,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] bit_count
);

  localparam int NUM_WORDS = (BITSTREAM_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int IDX_W     = $clog2(WORD_WIDTH);

  localparam logic [IDX_W-1:0]       IDX_PRE  = IDX_W'(WORD_WIDTH - 2);
  localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(WORD_WIDTH - 1);
  localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(BITSTREAM_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]  word_q, word_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   head_q, head_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    word_d  = word_q;
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    head_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          rd_en_d = 1'b1;
          addr_d  = '0;
          word_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
        busy_d  = 1'b1;
      end
      S_WAIT: begin
        state_d = S_SHIFT;
        shift_d = rom_data;
        idx_d   = '0;
        busy_d  = 1'b1;
        head_d  = rom_data[WORD_WIDTH-1];
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          // The prefetched word lands on rom_data exactly as the last bit leaves
          if (idx_q == IDX_LAST) begin
            shift_d = rom_data;
            idx_d   = '0;
            word_d  = word_q + ADDR_ONE;
          end else begin
            shift_d = shift_q << 1;
            idx_d   = idx_q + IDX_ONE;
          end
          head_d = shift_d[WORD_WIDTH-1];
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Issue the next-word read one cycle before its data is needed
    if ((state_d == S_SHIFT) && (idx_d == IDX_PRE) &&
        ((int'(word_d) + 1) < NUM_WORDS)) begin
      rd_en_d = 1'b1;
      addr_d  = word_d + ADDR_ONE;
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      head_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      head_q  <= head_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_rd_en         = rd_en_q;
  assign rom_addr          = addr_q;
  assign config_chain_head = head_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign bit_count         = cnt_q;

endmodule

// File: tb/tb_bitstream_rom_shifter.sv
// Bench for bitstream_rom_shifter: two configurations (L=10 and L=8, W=4)
// checked cycle-by-cycle against a bitstream/timing model built from the ROM image.
module tb_bitstream_rom_shifter;

  localparam int W  = 4;
  localparam int AW = 2;
  localparam int CW = 4;
  localparam int LA = 10;
  localparam int LB = 8;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic          prog_reset_n;
  logic          start_a, start_b;
  logic          rd_a, rd_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [W-1:0]  data_a, data_b;
  logic          head_a, head_b, busy_a, busy_b, done_a, done_b;
  logic [CW-1:0] cnt_a, cnt_b;

  logic [W-1:0] rom_a [4];
  logic [W-1:0] rom_b [4];

  int vectors = 0;
  int miscompares = 0;
  bit sel;

  bitstream_rom_shifter #(.BITSTREAM_LENGTH(LA), .WORD_WIDTH(W), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut_a (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start_a),
    .rom_rd_en(rd_a), .rom_addr(addr_a), .rom_data(data_a),
    .config_chain_head(head_a), .busy(busy_a), .done(done_a), .bit_count(cnt_a));

  bitstream_rom_shifter #(.BITSTREAM_LENGTH(LB), .WORD_WIDTH(W), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut_b (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start_b),
    .rom_rd_en(rd_b), .rom_addr(addr_b), .rom_data(data_b),
    .config_chain_head(head_b), .busy(busy_b), .done(done_b), .bit_count(cnt_b));

  // Synchronous ROMs: data valid the cycle after the read strobe
  always @(posedge prog_clk) begin
    if (rd_a) data_a <= rom_a[addr_a];
    if (rd_b) data_b <= rom_b[addr_b];
  end

  logic          m_head, m_rd, m_busy, m_done;
  logic [AW-1:0] m_addr;
  logic [CW-1:0] m_cnt;
  assign m_head = sel ? head_b : head_a;
  assign m_rd   = sel ? rd_b   : rd_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_addr = sel ? addr_b : addr_a;
  assign m_cnt  = sel ? cnt_b  : cnt_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start_b = v;
    else   start_a = v;
  endtask

  task automatic do_reset();
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge prog_clk);
    prog_reset_n = 1'b0;
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_head"}, 32'(m_head), 32'd0);
    chk({tag, "_rd"},   32'(m_rd),   32'd0);
    chk({tag, "_addr"}, 32'(m_addr), 32'd0);
    chk({tag, "_busy"}, 32'(m_busy), 32'd0);
    chk({tag, "_done"}, 32'(m_done), 32'd0);
    chk({tag, "_cnt"},  32'(m_cnt),  32'd0);
  endtask

  // Run one load and compare every cycle with the expected bitstream and timing.
  // Cycle k counts negedges after the edge that samples start.
  task automatic load(input bit s, input int len, input bit toggle, input int abort_k);
    bit q[$];
    logic [W-1:0] word;
    int nw, nrd;
    logic exp_head, exp_rd;
    sel = s;
    nw = (len + W - 1) / W;
    for (int wi = 0; wi < nw; wi++) begin
      word = s ? rom_b[wi] : rom_a[wi];
      for (int b = W - 1; b >= 0; b--) q.push_back(word[b]);
    end
    nrd = 0;
    @(negedge prog_clk);
    set_start(s, 1'b1);
    @(posedge prog_clk);
    for (int k = 0; k <= len + 4; k++) begin
      @(negedge prog_clk);
      if (k == abort_k) begin
        prog_reset_n = 1'b0;
        set_start(s, 1'b0);
        #1;
        check_all_zero("async_rst");
        return;
      end
      if (toggle && k == 3) set_start(s, 1'b0);
      if (toggle && k == 5) set_start(s, 1'b1);
      if (toggle && k == 6) set_start(s, 1'b0);
      exp_head = (k >= 2 && k < len + 2) ? q[k-2] : 1'b0;
      exp_rd   = ((k % W) == 0) && ((k / W) < nw);
      chk($sformatf("head_k%0d", k), 32'(m_head), 32'(exp_head));
      chk($sformatf("rd_k%0d", k),   32'(m_rd),   32'(exp_rd));
      if (exp_rd) chk($sformatf("addr_k%0d", k), 32'(m_addr), 32'(k / W));
      chk($sformatf("done_k%0d", k), 32'(m_done), 32'(k >= len + 2));
      chk($sformatf("busy_k%0d", k), 32'(m_busy), 32'(k < len + 2));
      chk($sformatf("cnt_k%0d", k),  32'(m_cnt),
          32'((k < 2) ? 0 : (k < len + 2) ? k - 2 : len));
      if (m_rd === 1'b1) nrd++;
    end
    chk("read_pulses", 32'(nrd), 32'(nw));
    set_start(s, 1'b0);
  endtask

  initial begin
    prog_reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    sel = 1'b0;
    rom_a[0] = 4'hA; rom_a[1] = 4'h5; rom_a[2] = 4'hC; rom_a[3] = 4'h0;
    rom_b[0] = 4'hF; rom_b[1] = 4'h0; rom_b[2] = 4'h0; rom_b[3] = 4'h0;
    repeat (2) @(negedge prog_clk);
    check_all_zero("reset");
    prog_reset_n = 1'b1;

    // Idle with start low: nothing moves
    for (int i = 0; i < 20; i++) begin
      @(negedge prog_clk);
      check_all_zero($sformatf("idle%0d", i));
    end

    load(1'b0, LA, 1'b0, -1);

    do_reset();
    load(1'b1, LB, 1'b0, -1);

    // Reset after five bits, then full replay from address 0
    do_reset();
    load(1'b0, LA, 1'b0, 7);
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    load(1'b0, LA, 1'b0, -1);

    // start wiggling mid-shift, then re-pulsed while done
    do_reset();
    load(1'b0, LA, 1'b1, -1);
    start_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge prog_clk);
      chk("done_sticky", 32'(done_a), 32'd1);
      chk("done_no_rd",  32'(rd_a),   32'd0);
      chk("done_head",   32'(head_a), 32'd0);
      chk("done_cnt",    32'(cnt_a),  32'(LA));
    end
    start_a = 1'b0;

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) rom_a[i] = 4'($urandom);
      do_reset();
      load(1'b0, LA, 1'($urandom_range(0, 1)), -1);
    end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) rom_b[i] = 4'($urandom);
      do_reset();
      load(1'b1, LB, 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
